// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin shared barrel shifter with a one-deep registered result
// Optional SHIFT_ARB_PERF_EN adds the conflict_cnt stall counter output.
module shift_unit_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_data0,
    input  logic [4:0]   req_shamt0,
    input  logic [1:0]   req_ctrl0,
    input  logic [W-1:0] req_data1,
    input  logic [4:0]   req_shamt1,
    input  logic [1:0]   req_ctrl1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_data,
`ifdef SHIFT_ARB_PERF_EN
    output logic [15:0]  conflict_cnt,
`endif
    output logic         busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_grant_q, last_grant_d;
    logic [W-1:0]   data_q, data_d;
    logic           can_accept;
    logic           drain;
    logic [1:0]     grant;
    logic [W-1:0]   sel_data;
    logic [4:0]     sel_shamt;
    logic [1:0]     sel_ctrl;

    function automatic logic [W-1:0] shift_op(input logic [W-1:0] d,
                                              input logic [4:0]   s,
                                              input logic [1:0]   c);
        logic [2*W-1:0] dd;
        // Rotate: shifting the doubled word right leaves the rotated value in the low half.
        dd = {d, d} >> s;
        case (c)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return dd[W-1:0];
        endcase
    endfunction

    assign rsp_valid = (state_q == FULL) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign busy      = (state_q == FULL);
    assign drain     = (state_q == FULL) && rsp_ready[owner_q];
    assign can_accept = !reset && ((state_q == EMPTY) || drain);

    always_comb begin
        grant = 2'b00;
        if (can_accept) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel_data  = grant[1] ? req_data1  : req_data0;
    assign sel_shamt = grant[1] ? req_shamt1 : req_shamt0;
    assign sel_ctrl  = grant[1] ? req_ctrl1  : req_ctrl0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        if (grant != 2'b00) begin
            state_d      = FULL;
            owner_d      = grant[1];
            last_grant_d = grant[1];
            data_d       = shift_op(sel_data, sel_shamt, sel_ctrl);
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
        end
    end

`ifdef SHIFT_ARB_PERF_EN
    logic [1:0]  stall;
    logic [16:0] conflict_sum;
    logic [15:0] conflict_q, conflict_d;

    assign stall        = req_valid & ~req_ready;
    assign conflict_sum = {1'b0, conflict_q} + {16'd0, stall[0]} + {16'd0, stall[1]};
    assign conflict_d   = conflict_sum[16] ? 16'hFFFF : conflict_sum[15:0];
    assign conflict_cnt = conflict_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - randomized and directed bench against a behavioural arbiter model
module tb_shift_unit_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_ready;
    logic [W-1:0] req_data0, req_data1;
    logic [4:0]   req_shamt0, req_shamt1;
    logic [1:0]   req_ctrl0, req_ctrl1;
    logic [1:0]   rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data;
    logic         busy;
`ifdef SHIFT_ARB_PERF_EN
    logic [15:0]  conflict_cnt;
`endif

    shift_unit_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_shamt0(req_shamt0), .req_ctrl0(req_ctrl0),
        .req_data1(req_data1), .req_shamt1(req_shamt1), .req_ctrl1(req_ctrl1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef SHIFT_ARB_PERF_EN
        .conflict_cnt(conflict_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit           m_full;
    int           m_owner;
    int           m_last;
    int           m_conf;
    logic [W-1:0] m_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input int c);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case (c)
                0: r[i] = (i >= s) ? d[i-s] : 1'b0;
                1: r[i] = (i + s < W) ? d[i+s] : 1'b0;
                2: r[i] = (i + s < W) ? d[i+s] : d[W-1];
                default: r[i] = d[(i+s)%W];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_full  = 1'b0;
        m_owner = 0;
        m_last  = 1;
        m_conf  = 0;
        m_data  = '0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int   win;
        logic [1:0] er;
        bit   can;
        can = !m_full || rsp_ready[m_owner];
        win = -1;
        if (can) begin
            if (req_valid == 2'b11)      win = (m_last == 0) ? 1 : 0;
            else if (req_valid == 2'b01) win = 0;
            else if (req_valid == 2'b10) win = 1;
        end
        er = 2'b00;
        if (win >= 0) er[win] = 1'b1;
        #1;
        check_eq("req_ready", req_ready, er);
        check_eq("busy", busy, m_full);
        check_eq("rsp_valid", rsp_valid, m_full ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00);
        if (m_full) check_eq("rsp_data", rsp_data, m_data);
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            if (req_valid[i] && !er[i] && m_conf < 16'hFFFF) m_conf++;
        if (win >= 0) begin
            m_full  = 1'b1;
            m_owner = win;
            m_last  = win;
            m_data  = (win == 1) ? ref_shift(req_data1, req_shamt1, req_ctrl1)
                                 : ref_shift(req_data0, req_shamt0, req_ctrl0);
        end else if (m_full && rsp_ready[m_owner]) begin
            m_full = 1'b0;
        end
        @(negedge clk);
`ifdef SHIFT_ARB_PERF_EN
        check_eq("conflict_cnt", conflict_cnt, m_conf);
`endif
    endtask

    // Asserted mid-cycle so the checks see the asynchronous effect before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_rsp_data", rsp_data, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b11;
        rsp_ready  = 2'b00;
        req_data0  = '0; req_shamt0 = '0; req_ctrl0 = '0;
        req_data1  = '0; req_shamt1 = '0; req_ctrl1 = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request LSL
        req_valid = 2'b01; req_data0 = 32'h1; req_shamt0 = 5'd4; req_ctrl0 = 2'b00; rsp_ready = 2'b11;
        step();
        check_eq("t1_data", rsp_data, 32'h10);
        check_eq("t1_valid", rsp_valid, 2'b01);
        req_valid = 2'b00;
        step();

        // Tie from reset, strict alternation
        do_reset();
        req_valid = 2'b11;
        req_data0 = 32'h8000_0000; req_shamt0 = 5'd31; req_ctrl0 = 2'b10;
        req_data1 = 32'h0000_0001; req_shamt1 = 5'd1;  req_ctrl1 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t2_data", rsp_data, (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000);
        end
`ifdef SHIFT_ARB_PERF_EN
        check_eq("t6_conflict4", conflict_cnt, 16'd4);
`endif
        req_valid = 2'b00;
        step();

        // Backpressure then same-cycle drain/refill
        req_valid = 2'b01; req_data0 = 32'hF000_0000; req_shamt0 = 5'd28; req_ctrl0 = 2'b01;
        step();
        rsp_ready = 2'b00; req_valid = 2'b10; req_data1 = 32'h1234_5678; req_shamt1 = 5'd8; req_ctrl1 = 2'b00;
        for (int k = 0; k < 3; k++) step();
        check_eq("t3_hold", rsp_data, 32'h0000_000F);
        rsp_ready = 2'b01;
        step();
        check_eq("t3_refill", rsp_data, 32'h3456_7800);
        req_valid = 2'b00; rsp_ready = 2'b11;
        step();

        // shamt=0 passthrough, back-to-back
        for (int c = 0; c < 4; c++) begin
            req_valid = 2'b01; req_data0 = 32'hA5A5_A5A5; req_shamt0 = 5'd0; req_ctrl0 = 2'(c);
            step();
            check_eq("t4_pass", rsp_data, 32'hA5A5_A5A5);
        end
        req_valid = 2'b00;
        step();

        // Reset while FULL and stalled, then tie goes to requester 0
        req_valid = 2'b10; req_data1 = 32'hDEAD_BEEF; req_shamt1 = 5'd3; req_ctrl1 = 2'b11;
        step();
        rsp_ready = 2'b00; req_valid = 2'b00;
        step();
        do_reset();
        req_valid = 2'b11; rsp_ready = 2'b11;
        step();
        check_eq("t5_tie", rsp_valid, 2'b01);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            req_valid  = 2'($urandom);
            req_data0  = $urandom; req_shamt0 = 5'($urandom); req_ctrl0 = 2'($urandom);
            req_data1  = $urandom; req_shamt1 = 5'($urandom); req_ctrl1 = 2'($urandom);
            rsp_ready  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            step();
        end

`ifdef SHIFT_ARB_PERF_EN
        req_valid = 2'b01; rsp_ready = 2'b11;
        step();
        req_valid = 2'b11; rsp_ready = 2'b00;
        for (int k = 0; k < 33000; k++) @(negedge clk);
        check_eq("t6_saturate", conflict_cnt, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
